output_writeback: RTL

OUTPUT_WRITEBACK -- requirements
Module: output_writeback

---
 rtl/accel_pkg.sv | 16 +
 rtl/owb_skid.sv | 45 ++++
 rtl/output_writeback.sv | 119 +++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// Shared accelerator definitions: writeback FSM states and default geometry.
package accel_pkg;

  localparam int OWB_DATA_W  = 16;
  localparam int OWB_ADDR_W  = 13;
  localparam int OWB_OUT_LEN = 31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_COPY,
    S_DRAIN,
    S_DONE
  } owb_state_t;

endpackage

// File: rtl/owb_skid.sv
// One-word hold register for output_writeback.
// It catches a returned word when the share grant is lost, and it replays that word first.
module owb_skid #(
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_clr,
  input  logic              i_gnt,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_wr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_hold_valid
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_comb begin
    o_hold_valid = r_valid;
    o_wr         = i_gnt && (r_valid || i_in_valid);
    o_wr_data    = r_valid ? r_data : i_in_data;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (r_valid) begin
      // The hold word drains first; a word arriving in the same cycle takes its place.
      if (i_gnt) begin
        r_valid <= i_in_valid;
        if (i_in_valid) r_data <= i_in_data;
      end
    end else if (i_in_valid && !i_gnt) begin
      r_valid <= 1'b1;
      r_data  <= i_in_data;
    end
  end

endmodule

// File: rtl/output_writeback.sv
// Copies OUT_LEN words from the output buffer into share memory at OADDR, under arbiter grant.
// Optional macro OWB_RELU_EN: negative words are written as zero.
module output_writeback
  import accel_pkg::*;
#(
  parameter int DATA_W  = OWB_DATA_W,
  parameter int ADDR_W  = OWB_ADDR_W,
  parameter int OUT_LEN = OWB_OUT_LEN
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] OADDR,
  output logic              BUSY,
  output logic              DONE,
  output logic              output_cen,
  output logic              output_ren,
  output logic [ADDR_W-1:0] output_addr,
  input  logic [DATA_W-1:0] output_rdata,
  output logic              share_req,
  input  logic              share_gnt,
  output logic              share_cen,
  output logic              share_wen,
  output logic [ADDR_W-1:0] share_addr,
  output logic [DATA_W-1:0] share_wdata
);

  localparam int               CNT_W = $clog2(OUT_LEN + 1);
  localparam logic [CNT_W-1:0] LEN   = CNT_W'(OUT_LEN);

  owb_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_oaddr;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic              r_rd_pend;

  logic              w_accept;
  logic              w_read;
  logic              w_wr;
  logic              w_hold_valid;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_wr_data;

  always_comb begin
`ifdef OWB_RELU_EN
    w_word = output_rdata[DATA_W-1] ? '0 : output_rdata;
`else
    w_word = output_rdata;
`endif
  end

  always_comb begin
    w_accept = (r_state == S_IDLE) && START;
    w_read   = (r_state == S_COPY) && share_gnt && (r_rd_cnt < LEN)
               && !(w_hold_valid && !share_gnt);
  end

  owb_skid #(
    .DATA_W(DATA_W)
  ) u_skid (
    .CLK         (CLK),
    .RESET       (RESET),
    .i_clr       (w_accept),
    .i_gnt       (share_gnt),
    .i_in_valid  (r_rd_pend),
    .i_in_data   (w_word),
    .o_wr        (w_wr),
    .o_wr_data   (w_wr_data),
    .o_hold_valid(w_hold_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (START) w_state_nxt = S_REQ;
      S_REQ:   if (share_gnt) w_state_nxt = S_COPY;
      S_COPY:  if (r_rd_cnt == LEN) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_wr_cnt == LEN) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= S_IDLE;
      r_oaddr   <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_pend <= w_read;
      if (w_accept) begin
        r_oaddr  <= OADDR;
        r_rd_cnt <= '0;
        r_wr_cnt <= '0;
      end else begin
        if (w_read) r_rd_cnt <= r_rd_cnt + 1'b1;
        if (w_wr)   r_wr_cnt <= r_wr_cnt + 1'b1;
      end
    end
  end

  // Strobes are decoded straight from state so an asynchronous reset silences them at once.
  always_comb begin
    BUSY        = (r_state != S_IDLE);
    DONE        = (r_state == S_DONE);
    share_req   = (r_state == S_REQ) || (r_state == S_COPY) || (r_state == S_DRAIN);
    output_cen  = !w_read;
    output_ren  = w_read;
    output_addr = w_read ? ADDR_W'(r_rd_cnt) : '0;
    share_cen   = !w_wr;
    share_wen   = !w_wr;
    share_addr  = w_wr ? (r_oaddr + ADDR_W'(r_wr_cnt)) : '0;
    share_wdata = w_wr ? w_wr_data : '0;
  end

endmodule
